// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl: turns the UART receiver byte stream into framed command packets.
// Frame: SYNC CMD LEN payload[LEN] CHK. Optional stats outputs: define PKT_STATS_EN.
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 4,
    parameter int         TIMEOUT_CLKS = 5400
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_received,
    input  logic [7:0]  rx_data,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [7:0]  pkt_cmd,
    output logic [2:0]  pkt_len,
    output logic [31:0] pkt_payload,
    output logic        err_checksum,
    output logic        err_length,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic        busy
`ifdef PKT_STATS_EN
    ,
    output logic [15:0] good_count,
    output logic [15:0] err_count
`endif
);

    localparam int CW = $clog2(TIMEOUT_CLKS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_HOLD = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [2:0]    sync_q;
    logic          byte_stb;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    acc_q, acc_d;
    logic [2:0]    len_q, len_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   pay_q, pay_d;
    logic          valid_q, valid_d;
    logic [7:0]    ocmd_q, ocmd_d;
    logic [2:0]    olen_q, olen_d;
    logic [31:0]   opay_q, opay_d;
    logic          echk_q, echk_d;
    logic          elen_q, elen_d;
    logic          eto_q, eto_d;
    logic          eovr_q, eovr_d;
    logic          in_frame;

    // Strobe on the synchronized rising edge of the receiver done level
    assign byte_stb = sync_q[1] & ~sync_q[2];
    assign in_frame = (state_q != S_IDLE) && (state_q != S_HOLD);

    // Frame sequencing, checksum accumulation and timeout supervision
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        acc_d   = acc_q;
        len_d   = len_q;
        idx_d   = idx_q;
        pay_d   = pay_q;
        valid_d = valid_q;
        ocmd_d  = ocmd_q;
        olen_d  = olen_q;
        opay_d  = opay_q;
        echk_d  = 1'b0;
        elen_d  = 1'b0;
        eto_d   = 1'b0;
        eovr_d  = 1'b0;
        cnt_d   = in_frame ? cnt_q + CW'(1) : '0;
        if (byte_stb) cnt_d = '0;
        case (state_q)
            S_IDLE: begin
                if (byte_stb && rx_data == SYNC_BYTE) begin
                    state_d = S_CMD;
                    pay_d   = '0;
                    len_d   = '0;
                    idx_d   = '0;
                end
            end
            S_CMD: begin
                if (byte_stb) begin
                    cmd_d   = rx_data;
                    acc_d   = rx_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (byte_stb) begin
                    if (rx_data > 8'(MAX_LEN)) begin
                        elen_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        acc_d = acc_q ^ rx_data;
                        len_d = rx_data[2:0];
                        idx_d = '0;
                        state_d = (rx_data == 8'd0) ? S_CHK : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_stb) begin
                    pay_d[{idx_q, 3'b000} +: 8] = rx_data;
                    acc_d = acc_q ^ rx_data;
                    idx_d = idx_q + 2'd1;
                    if ({1'b0, idx_q} == len_q - 3'd1) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (byte_stb) begin
                    if (rx_data == acc_q) begin
                        ocmd_d  = cmd_q;
                        olen_d  = len_q;
                        opay_d  = pay_q;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        echk_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (byte_stb) eovr_d = 1'b1;
                if (valid_q && pkt_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (in_frame && !byte_stb && cnt_q == CW'(TIMEOUT_CLKS - 2)) begin
            eto_d   = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // State, datapath and error pulse registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
            acc_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            pay_q   <= '0;
            valid_q <= 1'b0;
            ocmd_q  <= '0;
            olen_q  <= '0;
            opay_q  <= '0;
            echk_q  <= 1'b0;
            elen_q  <= 1'b0;
            eto_q   <= 1'b0;
            eovr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], rx_received};
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            pay_q   <= pay_d;
            valid_q <= valid_d;
            ocmd_q  <= ocmd_d;
            olen_q  <= olen_d;
            opay_q  <= opay_d;
            echk_q  <= echk_d;
            elen_q  <= elen_d;
            eto_q   <= eto_d;
            eovr_q  <= eovr_d;
        end
    end

    assign pkt_valid    = valid_q;
    assign pkt_cmd      = ocmd_q;
    assign pkt_len      = olen_q;
    assign pkt_payload  = opay_q;
    assign err_checksum = echk_q;
    assign err_length   = elen_q;
    assign err_timeout  = eto_q;
    assign err_overrun  = eovr_q;
    assign busy         = (state_q != S_IDLE);

`ifdef PKT_STATS_EN
    logic [15:0] good_q, errc_q;

    // Saturating counts of accepted packets and error events
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            good_q <= '0;
            errc_q <= '0;
        end else begin
            if (valid_q && pkt_ready && good_q != 16'hFFFF)
                good_q <= good_q + 16'd1;
            if ((echk_d | elen_d | eto_d | eovr_d) && errc_q != 16'hFFFF)
                errc_q <= errc_q + 16'd1;
        end
    end

    assign good_count = good_q;
    assign err_count  = errc_q;
`endif

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// tb_uart_rx_packet_ctrl: scoreboard bench for the UART packet framer.
// Directed frames from the test plan followed by randomized frames.
module tb_uart_rx_packet_ctrl;

    localparam int T = 5400;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_received = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        pkt_ready = 1'b1;
    logic        pkt_valid;
    logic [7:0]  pkt_cmd;
    logic [2:0]  pkt_len;
    logic [31:0] pkt_payload;
    logic        err_checksum, err_length, err_timeout, err_overrun, busy;

    uart_rx_packet_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .rx_received(rx_received), .rx_data(rx_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_cmd(pkt_cmd), .pkt_len(pkt_len), .pkt_payload(pkt_payload),
        .err_checksum(err_checksum), .err_length(err_length),
        .err_timeout(err_timeout), .err_overrun(err_overrun),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  cmd;
        logic [2:0]  len;
        logic [31:0] pay;
    } pkt_t;

    pkt_t       exp_pkt[$];
    int         exp_err[$];
    logic [7:0] txq[$];
    int         errors = 0;
    int         checks = 0;
    int         t_to = -1;
    int         last_rise = 0;
    pkt_t       got;
    logic [3:0] errv;
    int         e_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sampled mid low phase, away from both edges
    always @(negedge clock) begin
        #2;
        if (reset_n) begin
            if (pkt_valid && pkt_ready) begin
                if (exp_pkt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pkt: got cmd %h expected none", pkt_cmd);
                end else begin
                    got = exp_pkt.pop_front();
                    chk("pkt_cmd", 32'(pkt_cmd), 32'(got.cmd));
                    chk("pkt_len", 32'(pkt_len), 32'(got.len));
                    chk("pkt_payload", pkt_payload, got.pay);
                end
            end
            errv = {err_overrun, err_timeout, err_length, err_checksum};
            for (int k = 0; k < 4; k++) begin
                if (errv[k]) begin
                    if (k == 2) t_to = cyc;
                    if (exp_err.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_err: got code %0d expected none", k);
                    end else begin
                        e_code = exp_err.pop_front();
                        chk("err_code", 32'(k), 32'(e_code));
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_data = b;
        rx_received = 1'b1;
        last_rise = cyc;
        repeat ($urandom_range(3, 8)) @(negedge clock);
        rx_received = 1'b0;
        repeat ($urandom_range(3, 8)) @(negedge clock);
    endtask

    task automatic send_all();
        for (int i = 0; i < txq.size(); i++) send_byte(txq[i]);
        txq.delete();
    endtask

    task automatic push_pkt(input logic [7:0] c, input logic [2:0] l, input logic [31:0] p);
        pkt_t e;
        e.cmd = c;
        e.len = l;
        e.pay = p;
        exp_pkt.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  c, l, b, acc;
        logic [31:0] pay;
        int          kind;

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_valid", 32'(pkt_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd", 32'(pkt_cmd), 0);
        chk("rst_len", 32'(pkt_len), 0);
        chk("rst_payload", pkt_payload, 0);
        chk("rst_errs", 32'({err_checksum, err_length, err_timeout, err_overrun}), 0);

        // Basic good frame
        push_pkt(8'h10, 3'd2, 32'h0000_7F03);
        txq = '{8'hA5, 8'h10, 8'h02, 8'h03, 8'h7F, 8'h6E};
        send_all();

        // Checksum mismatch
        exp_err.push_back(0);
        txq = '{8'hA5, 8'h10, 8'h02, 8'h03, 8'h7F, 8'h6F};
        send_all();
        chk("chk_busy_after", 32'(busy), 0);
        chk("chk_no_valid", 32'(pkt_valid), 0);

        // Length error then zero-length frame
        exp_err.push_back(1);
        txq = '{8'hA5, 8'h20, 8'h05};
        send_all();
        chk("len_busy_after", 32'(busy), 0);
        push_pkt(8'h21, 3'd0, 32'h0);
        txq = '{8'hA5, 8'h21, 8'h00, 8'h21};
        send_all();

        // Inter-byte timeout and its latency
        exp_err.push_back(2);
        t_to = -1;
        txq = '{8'hA5, 8'h10};
        send_all();
        for (int i = 0; i < T + 100 && t_to < 0; i++) @(negedge clock);
        @(negedge clock);
        chk("timeout_latency", 32'(t_to), 32'(last_rise + T + 2));
        chk("timeout_busy", 32'(busy), 0);
        push_pkt(8'h30, 3'd0, 32'h0);
        txq = '{8'hA5, 8'h30, 8'h00, 8'h30};
        send_all();

        // Overrun while holding a packet
        pkt_ready = 1'b0;
        push_pkt(8'h40, 3'd1, 32'h0000_0011);
        txq = '{8'hA5, 8'h40, 8'h01, 8'h11, 8'h50};
        send_all();
        chk("hold_valid", 32'(pkt_valid), 1);
        chk("hold_busy", 32'(busy), 1);
        exp_err.push_back(3);
        send_byte(8'h55);
        chk("ovr_valid", 32'(pkt_valid), 1);
        chk("ovr_cmd", 32'(pkt_cmd), 32'h40);
        chk("ovr_payload", pkt_payload, 32'h11);
        pkt_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("ack_valid_drop", 32'(pkt_valid), 0);
        chk("ack_busy", 32'(busy), 0);

        // Reset in the middle of a frame
        txq = '{8'hA5, 8'h10, 8'h04, 8'h01, 8'h02};
        send_all();
        chk("mid_busy", 32'(busy), 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cmd", 32'(pkt_cmd), 0);
        chk("arst_len", 32'(pkt_len), 0);
        chk("arst_payload", pkt_payload, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        push_pkt(8'h10, 3'd1, 32'h0000_0009);
        txq = '{8'hA5, 8'h10, 8'h01, 8'h09, 8'h18};
        send_all();

        // Randomized frames with interleaved noise bytes
        for (int f = 0; f < 30; f++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                txq.push_back(b);
            end
            kind = $urandom_range(0, 9);
            c = 8'($urandom);
            txq.push_back(8'hA5);
            txq.push_back(c);
            if (kind == 0) begin
                l = 8'($urandom_range(5, 255));
                txq.push_back(l);
                exp_err.push_back(1);
            end else begin
                l = 8'($urandom_range(0, 4));
                txq.push_back(l);
                acc = c ^ l;
                pay = 32'h0;
                for (int i = 0; i < int'(l); i++) begin
                    b = 8'($urandom);
                    txq.push_back(b);
                    acc = acc ^ b;
                    pay = pay | (32'(b) << (8 * i));
                end
                if (kind == 1) begin
                    txq.push_back(acc ^ 8'(1 << $urandom_range(0, 7)));
                    exp_err.push_back(0);
                end else begin
                    txq.push_back(acc);
                    push_pkt(c, l[2:0], pay);
                end
            end
            send_all();
        end

        repeat (20) @(negedge clock);
        chk("pkt_queue_drained", 32'(exp_pkt.size()), 0);
        chk("err_queue_drained", 32'(exp_err.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_packet_ctrl.md
Name: uart_rx_packet_ctrl

Overview:
Sequences the UART byte receiver's output stream into framed command packets for the game logic.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK.
- Checks the checksum, bounds LEN and enforces an inter-byte timeout.
- Hands each complete packet to the consumer on a valid/ready handshake.
- Sits between the receiver (received/received_data) and the game command decoder.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
MAX_LEN, 4, maximum payload bytes (1..4; payload bus is 32 bits)
TIMEOUT_CLKS, 5400, clocks allowed between bytes inside a frame (10 byte times at 54 clk/bit)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_received  in  1  receiver byte-done level; high for about one bit period per byte
rx_data  in  8  receiver byte; stable from rx_received rise until next byte
pkt_valid  out  1  packet available
pkt_ready  in  1  consumer accepts packet when high with pkt_valid
pkt_cmd  out  8  command byte
pkt_len  out  3  payload byte count 0..MAX_LEN
pkt_payload  out  32  payload; byte i in bits [8i+7:8i]; unused bytes zero
err_checksum  out  1  one-clock pulse: CHK mismatch
err_length  out  1  one-clock pulse: LEN > MAX_LEN
err_timeout  out  1  one-clock pulse: inter-byte timeout
err_overrun  out  1  one-clock pulse: byte dropped while holding a packet
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: everything asynchronously cleared.
  - State IDLE.
  - pkt_valid, all err_* and busy = 0.
  - pkt_cmd, pkt_len, pkt_payload = 0.
  - Timeout counter, synchronizer and edge detector = 0.
- Byte strobe:
  - rx_received passes through a 2-flop synchronizer, then a rising-edge detector, producing byte_stb (one clock).
  - byte_stb occurs 3 clocks after the rx_received rise.
  - rx_data is captured on byte_stb.
  - A level held high produces exactly one strobe.
- Checksum: acc = XOR of CMD, LEN and all payload bytes. acc clears on entry to CMD.
- Timeout counter:
  - Cleared on every byte_stb and in IDLE/HOLD.
  - Increments in CMD/LEN/DATA/CHK.
  - On reaching TIMEOUT_CLKS-1: pulse err_timeout, go to IDLE, discard the partial frame.
- States:
  - IDLE: byte_stb with byte == SYNC_BYTE -> CMD. Any other byte is ignored with no error.
  - CMD: byte_stb -> latch cmd, acc = byte -> LEN.
  - LEN, byte_stb:
    - byte > MAX_LEN: pulse err_length -> IDLE.
    - byte == 0: -> CHK.
    - otherwise: latch len, idx = 0 -> DATA.
  - DATA: byte_stb -> payload[idx] = byte, acc ^= byte, idx++. When idx reaches len-1 on this byte -> CHK.
  - CHK, byte_stb:
    - byte == acc: load pkt_* outputs, pkt_valid = 1 -> HOLD.
    - byte != acc: pulse err_checksum -> IDLE. pkt_* outputs keep their previous values.
  - HOLD:
    - pkt_valid && pkt_ready -> pkt_valid = 0 next clock -> IDLE.
    - byte_stb in HOLD (including the same clock as ready): pulse err_overrun, byte dropped, no state change from the byte.
- Content rules:
  - SYNC_BYTE appearing inside a frame is treated as ordinary data; there is no resync.
  - pkt_cmd, pkt_len and pkt_payload are stable while pkt_valid = 1.
  - Unused payload bytes are zeroed when a new frame begins.
- Latency: pkt_valid rises 1 clock after the CHK byte_stb.
- Width: pkt_len is 3 bits. The LEN comparison uses the full 8-bit byte, so 0xFF is a length error, not wrap-around.
- Reset mid-frame or mid-HOLD aborts immediately to IDLE with outputs cleared.

Optional Feature:
Macro PKT_STATS_EN.
- Defined: adds outputs good_count[15:0] and err_count[15:0].
  - good_count increments on each pkt_valid&&pkt_ready.
  - err_count increments on any err_* pulse; simultaneous pulses count once.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Bytes A5 10 02 03 7F 6E with pkt_ready=1 -> one pkt_valid pulse; pkt_cmd=10, pkt_len=2, pkt_payload=32'h00007F03; no err_*.
- Bytes A5 10 02 03 7F 6F -> err_checksum pulse once; pkt_valid stays 0; busy=0 afterwards.
- Bytes A5 20 05 -> err_length pulse on the LEN byte; a following valid frame A5 21 00 21 -> pkt_cmd=21, pkt_len=0, payload=0.
- Bytes A5 10, then idle 5400 clocks -> err_timeout exactly TIMEOUT_CLKS-1 clocks after the last byte_stb; then A5 30 00 30 is accepted.
- Valid frame with pkt_ready=0, then byte 55 -> err_overrun pulse; outputs unchanged; raise ready -> pkt_valid drops next clock; state IDLE.
- Assert reset_n=0 during DATA of A5 10 04 01 02 -> outputs zero immediately; after release, a complete frame A5 10 01 09 18 is received correctly.
